// File: rtl/zone_stat_cal.sv
// Per-zone luminance statistics: max, rounded mean and blended backlight level
// for each zone of words arriving in block order from the frame buffer.
module zone_stat_cal #(
  parameter int WORDS_PER_ZONE = 477,
  parameter int ZONES          = 360,
  parameter int MEAN_K         = 2198,
  parameter int MEAN_SH        = 22,
  parameter int BL_WMAX        = 3
) (
  input  logic        i_pix_clk,
  input  logic        rst_n,
  input  logic        i_frame_start,
  input  logic        i_rd_valid,
  input  logic [31:0] i_rd_data,
  output logic        o_zone_valid,
  output logic [8:0]  o_zone_idx,
  output logic [7:0]  o_zone_max,
  output logic [7:0]  o_zone_mean,
  output logic [7:0]  o_zone_bl,
  output logic        o_frame_done
);

  localparam int WW = $clog2(WORDS_PER_ZONE);

  logic          a_vld_q, a_start_q;
  logic [31:0]   a_data_q;
  logic [WW-1:0] word_q, word_d, word_eff;
  logic [8:0]    zone_q, zone_d, zone_eff;
  logic [7:0]    acc_max_q, acc_max_d;
  logic [18:0]   acc_sum_q, acc_sum_d;
  logic          b_done_q, b_done_d;
  logic [8:0]    b_idx_q, b_idx_d;
  logic          c_vld_q;
  logic [7:0]    c_max_q, c_max_d;
  logic [18:0]   c_sum_q, c_sum_d;
  logic [8:0]    c_idx_q, c_idx_d;
  logic          m_vld_q;
  logic [30:0]   m_prod_q, m_prod_d;
  logic [7:0]    m_max_q, m_max_d;
  logic [8:0]    m_idx_q, m_idx_d;
  logic          o_zone_valid_d, o_frame_done_d;
  logic [8:0]    o_zone_idx_d;
  logic [7:0]    o_zone_max_d, o_zone_mean_d, o_zone_bl_d;
  logic [7:0]    w_max, pix;
  logic [9:0]    w_sum;
  logic          is_last;
  logic [30:0]   rnd, mean_full;
  logic [7:0]    mean8;
  logic [10:0]   blend;

  always_comb begin
    w_max = a_data_q[7:0];
    w_sum = '0;
    pix   = '0;
    for (int n = 0; n < 4; n++) begin
      pix = a_data_q[8*n +: 8];
      if (pix > w_max) w_max = pix;
      w_sum = w_sum + 10'(pix);
    end
  end

  // A frame start seen alongside a word makes that word word 0 of zone 0.
  always_comb begin
    word_eff  = a_start_q ? '0 : word_q;
    zone_eff  = a_start_q ? '0 : zone_q;
    is_last   = a_vld_q && (word_eff == WW'(WORDS_PER_ZONE - 1));
    word_d    = word_eff;
    zone_d    = zone_eff;
    acc_max_d = acc_max_q;
    acc_sum_d = acc_sum_q;
    if (a_vld_q) begin
      if (word_eff == '0) begin
        acc_max_d = w_max;
        acc_sum_d = 19'(w_sum);
      end else begin
        acc_max_d = (w_max > acc_max_q) ? w_max : acc_max_q;
        acc_sum_d = acc_sum_q + 19'(w_sum);
      end
      if (is_last) begin
        word_d = '0;
        zone_d = (zone_eff == 9'(ZONES - 1)) ? '0 : zone_eff + 9'd1;
      end else begin
        word_d = word_eff + WW'(1);
      end
    end
    b_done_d = is_last;
    b_idx_d  = is_last ? zone_eff : b_idx_q;
  end

  always_comb begin
    c_max_d  = b_done_q ? acc_max_q : c_max_q;
    c_sum_d  = b_done_q ? acc_sum_q : c_sum_q;
    c_idx_d  = b_done_q ? b_idx_q   : c_idx_q;
    m_prod_d = c_vld_q ? 31'(c_sum_q) * 31'(MEAN_K) : m_prod_q;
    m_max_d  = c_vld_q ? c_max_q : m_max_q;
    m_idx_d  = c_vld_q ? c_idx_q : m_idx_q;
  end

  always_comb begin
    rnd       = m_prod_q + 31'(2 ** (MEAN_SH - 1));
    mean_full = rnd >> MEAN_SH;
    mean8     = (|mean_full[30:8]) ? 8'hFF : mean_full[7:0];
    blend     = (11'(m_max_q) * 11'(BL_WMAX) + 11'(mean8) * 11'(8 - BL_WMAX)) >> 3;
    o_zone_valid_d = m_vld_q;
    o_frame_done_d = m_vld_q && (m_idx_q == 9'(ZONES - 1));
    o_zone_idx_d   = o_zone_idx;
    o_zone_max_d   = o_zone_max;
    o_zone_mean_d  = o_zone_mean;
    o_zone_bl_d    = o_zone_bl;
    if (m_vld_q) begin
      o_zone_idx_d  = m_idx_q;
      o_zone_max_d  = m_max_q;
      o_zone_mean_d = mean8;
      o_zone_bl_d   = blend[7:0];
    end
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q      <= 1'b0;
      a_start_q    <= 1'b0;
      a_data_q     <= '0;
      word_q       <= '0;
      zone_q       <= '0;
      acc_max_q    <= '0;
      acc_sum_q    <= '0;
      b_done_q     <= 1'b0;
      b_idx_q      <= '0;
      c_vld_q      <= 1'b0;
      c_max_q      <= '0;
      c_sum_q      <= '0;
      c_idx_q      <= '0;
      m_vld_q      <= 1'b0;
      m_prod_q     <= '0;
      m_max_q      <= '0;
      m_idx_q      <= '0;
      o_zone_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_zone_idx   <= '0;
      o_zone_max   <= '0;
      o_zone_mean  <= '0;
      o_zone_bl    <= '0;
    end else begin
      a_vld_q      <= i_rd_valid;
      a_start_q    <= i_frame_start;
      a_data_q     <= i_rd_data;
      word_q       <= word_d;
      zone_q       <= zone_d;
      acc_max_q    <= acc_max_d;
      acc_sum_q    <= acc_sum_d;
      b_done_q     <= b_done_d;
      b_idx_q      <= b_idx_d;
      c_vld_q      <= b_done_q;
      c_max_q      <= c_max_d;
      c_sum_q      <= c_sum_d;
      c_idx_q      <= c_idx_d;
      m_vld_q      <= c_vld_q;
      m_prod_q     <= m_prod_d;
      m_max_q      <= m_max_d;
      m_idx_q      <= m_idx_d;
      o_zone_valid <= o_zone_valid_d;
      o_frame_done <= o_frame_done_d;
      o_zone_idx   <= o_zone_idx_d;
      o_zone_max   <= o_zone_max_d;
      o_zone_mean  <= o_zone_mean_d;
      o_zone_bl    <= o_zone_bl_d;
    end
  end

endmodule

// File: tb/tb_zone_stat_cal.sv
// Bench for zone_stat_cal: full-size instance against a zone-level model, plus a
// short-zone instance used to walk a whole 360-zone frame.
module tb_zone_stat_cal;

  localparam int WPZ   = 477;
  localparam int F_WPZ = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0, rd_valid = 1'b0;
  logic [31:0] rd_data = '0;
  logic        zone_valid, frame_done;
  logic [8:0]  zone_idx;
  logic [7:0]  zone_max, zone_mean, zone_bl;

  logic        f_start = 1'b0, f_valid = 1'b0;
  logic [31:0] f_data = '0;
  logic        f_zone_valid, f_frame_done;
  logic [8:0]  f_zone_idx;
  logic [7:0]  f_zone_max, f_zone_mean, f_zone_bl;

  always #5 clk = ~clk;

  zone_stat_cal dut (
    .i_pix_clk(clk), .rst_n(rst_n), .i_frame_start(frame_start),
    .i_rd_valid(rd_valid), .i_rd_data(rd_data),
    .o_zone_valid(zone_valid), .o_zone_idx(zone_idx), .o_zone_max(zone_max),
    .o_zone_mean(zone_mean), .o_zone_bl(zone_bl), .o_frame_done(frame_done));

  zone_stat_cal #(.WORDS_PER_ZONE(F_WPZ), .MEAN_K(262144)) dut_f (
    .i_pix_clk(clk), .rst_n(rst_n), .i_frame_start(f_start),
    .i_rd_valid(f_valid), .i_rd_data(f_data),
    .o_zone_valid(f_zone_valid), .o_zone_idx(f_zone_idx), .o_zone_max(f_zone_max),
    .o_zone_mean(f_zone_mean), .o_zone_bl(f_zone_bl), .o_frame_done(f_frame_done));

  int total = 0, bad = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Zone-level model: collects pixels of the current zone and, once the zone is
  // complete, predicts its results and the cycle they must appear on.
  typedef struct {
    int idx; int mx; int mean; int bl; bit done; longint due;
  } exp_t;
  exp_t eq[$];
  exp_t e;
  int m_word = 0, m_zone = 0, m_max = 0;
  longint m_sum = 0;

  task automatic model_restart();
    m_word = 0; m_zone = 0; m_max = 0; m_sum = 0;
  endtask

  task automatic model_word(input logic [31:0] d, input bit st);
    exp_t x;
    int p;
    if (st) model_restart();
    if (m_word == 0) begin m_max = 0; m_sum = 0; end
    for (int n = 0; n < 4; n++) begin
      p = int'((d >> (8 * n)) & 32'hFF);
      if (p > m_max) m_max = p;
      m_sum += p;
    end
    if (m_word == WPZ - 1) begin
      x.idx  = m_zone;
      x.mx   = m_max;
      x.mean = int'((m_sum * 2198 + (64'd1 << 21)) >> 22);
      if (x.mean > 255) x.mean = 255;
      x.bl   = (3 * x.mx + 5 * x.mean) / 8;
      x.done = (m_zone == 359);
      x.due  = cyc + 5;
      eq.push_back(x);
      m_word = 0;
      m_zone = (m_zone + 1) % 360;
    end else begin
      m_word++;
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic [31:0] d);
    @(negedge clk);
    rd_valid = v; frame_start = st; rd_data = d;
    if (v) model_word(d, st);
    else if (st) model_restart();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic send_zone(input logic [31:0] d, input bit st);
    for (int w = 0; w < WPZ; w++) drive(1'b1, st && (w == 0), d);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (zone_valid) begin
        if (eq.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_valid: got idx %0d, expected no pulse (cycle %0d)", zone_idx, cyc);
        end else begin
          e = eq.pop_front();
          check("latency", cyc, e.due);
          check("idx", zone_idx, e.idx);
          check("max", zone_max, e.mx);
          check("mean", zone_mean, e.mean);
          check("bl", zone_bl, e.bl);
          check("frame_done", frame_done, e.done);
        end
      end else if (eq.size() > 0 && eq[0].due <= cyc) begin
        total++; bad++;
        $display("FAIL missing_valid: got no pulse, expected idx %0d at cycle %0d", eq[0].idx, eq[0].due);
        void'(eq.pop_front());
      end
      if (frame_done && !zone_valid) check("done_without_valid", 1, 0);
    end
  end

  int f_exp_idx = 0, f_pulses = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (f_zone_valid) begin
        check("f_idx", f_zone_idx, f_exp_idx);
        check("f_frame_done", f_frame_done, f_exp_idx == 359);
        check("f_max", f_zone_max, 64);
        check("f_mean", f_zone_mean, 64);
        f_exp_idx = (f_exp_idx + 1) % 360;
        f_pulses++;
      end else if (f_frame_done) begin
        check("f_done_without_valid", 1, 0);
      end
    end
  end

  task automatic check_outputs(input string tag, input int idx, input int mx, input int mean, input int bl);
    check({tag, "_idx"}, zone_idx, idx);
    check({tag, "_max"}, zone_max, mx);
    check({tag, "_mean"}, zone_mean, mean);
    check({tag, "_bl"}, zone_bl, bl);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 0, 0, 0);
    check("reset_valid", zone_valid, 0);
    rst_n = 1'b1;
    idle(2);

    // Flat 100 zone, then a lone 0xFF pixel in word 200.
    send_zone(32'h64646464, 1'b1);
    idle(8);
    check_outputs("flat100", 0, 100, 100, 100);
    for (int w = 0; w < WPZ; w++) drive(1'b1, 1'b0, (w == 200) ? 32'h0000FF00 : 32'h0);
    idle(8);
    check_outputs("single_ff", 1, 255, 0, 95);

    // Back-to-back zones at full rate; the second must not inherit the first.
    send_zone(32'hFFFFFFFF, 1'b1);
    send_zone(32'h10101010, 1'b0);
    idle(8);
    check_outputs("b2b_zone1", 1, 16, 16, 16);

    // Varied data through zones 0..4, abandon zone 5 at word 300.
    for (int z = 0; z < 5; z++)
      for (int w = 0; w < WPZ; w++)
        drive(1'b1, (z == 0) && (w == 0),
              {8'(w), 8'(z * 37 + w * 3), 8'(~w), 8'(w * 7)});
    for (int w = 0; w < 300; w++) drive(1'b1, 1'b0, 32'hC0C0C0C0);
    drive(1'b0, 1'b1, 32'h0);
    send_zone(32'h20202020, 1'b0);
    idle(8);
    check_outputs("restart", 0, 32, 32, 32);

    // Reset between a zone's last word and its result.
    send_zone(32'h80808080, 1'b0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b0;
    eq.delete();
    model_restart();
    idle(3);
    check_outputs("mid_reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    check_outputs("after_reset", 0, 0, 0, 0);
    check("after_reset_queue", eq.size(), 0);

    // Whole frame plus one zone on the short-zone instance, 1 word per 6 clocks.
    for (int z = 0; z < 361; z++)
      for (int w = 0; w < F_WPZ; w++) begin
        @(negedge clk);
        f_valid = 1'b1; f_start = (z == 0) && (w == 0); f_data = 32'h40404040;
        @(negedge clk);
        f_valid = 1'b0; f_start = 1'b0; f_data = 32'h0;
        repeat (4) @(negedge clk);
      end
    repeat (10) @(negedge clk);
    check("f_pulse_count", f_pulses, 361);
    check("f_wrap_idx", f_zone_idx, 0);

    idle(10);
    check("pending_results", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zone_stat_cal.md
# zone_stat_cal

Per-zone luminance statistics engine for the MiniLED local-dimming path. It sits directly downstream of the DDR3 block-order read-address generator. It consumes pixel words returned from the frame buffer in zone order: 9 words × 53 rows per zone, 24 zones per band, 15 bands. For each of the 360 backlight zones it produces max, mean and a weighted backlight level.

## Interface
Parameters:
- WORDS_PER_ZONE, 477: words per zone (9 × 53).
- ZONES, 360: zones per frame.
- MEAN_K, 2198: reciprocal multiplier, round(2^22 / 1908).
- MEAN_SH, 22: reciprocal shift.
- BL_WMAX, 3: weight of max in the backlight blend, out of 8.

Ports:
- i_pix_clk, in, 1: clock, all logic on the rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- i_frame_start, in, 1: one-cycle pulse; resynchronises to zone 0.
- i_rd_valid, in, 1: i_rd_data is valid this cycle.
- i_rd_data, in, 32: four 8-bit luma pixels; pixel n = bits [8n+7:8n].
- o_zone_valid, out, 1: one-cycle pulse; zone results valid.
- o_zone_idx, out, 9: zone index 0..359 of the results.
- o_zone_max, out, 8: maximum pixel in the zone.
- o_zone_mean, out, 8: rounded mean pixel value.
- o_zone_bl, out, 8: backlight level.
- o_frame_done, out, 1: pulses together with o_zone_valid for zone 359.

## Operation
- Word counter runs 0..WORDS_PER_ZONE-1 and advances on each i_rd_valid. Zone counter runs 0..359 and advances when a zone completes, wrapping 359→0.
- Per word: w_max is the max of the 4 pixels; w_sum is the sum of the 4 pixels (10 bits).
- Accumulators:
  - acc_max is 8 bits; acc_sum is 19 bits (max 1908×255 = 486540, no overflow).
  - On word 0, the accumulators load w_max / w_sum; they do not add to stale values. This lets a new zone start the cycle after the previous zone's last word.
  - On other words: acc_max = max(acc_max, w_max); acc_sum += w_sum.
- On the last word, the final acc_max/acc_sum, zone index and a finish flag are captured into the output pipeline. The accumulators are then free.
- mean = (acc_sum × MEAN_K + 2^(MEAN_SH−1)) >> MEAN_SH, using a 31-bit product, saturated to 255.
- bl = (max × BL_WMAX + mean × (8−BL_WMAX)) >> 3, using an 11-bit intermediate.
- i_frame_start:
  - Clears the word counter and zone counter and discards any partial zone; no output is produced for it.
  - Zones already in the output pipeline still complete normally.
- i_frame_start coincident with i_rd_valid: the frame start is applied first, and that word becomes word 0 of zone 0.
- i_rd_valid while i_rd_data holds X is a source error; no checking is done.

## Timing
- Pipeline:
  - Stage A: input register (word, valid).
  - Stage B: w_max/w_sum tree feeding the accumulators.
  - Stage C: finish capture plus multiply register.
  - Stage D: round/shift, blend, output register.
- Latency: o_zone_valid rises 4 cycles after the rising edge that samples the zone's last i_rd_valid word.
- The block accepts one word every cycle with no back-pressure. The upstream rate (1 per 6 clocks) is well within this.
- Outputs hold their values until the next o_zone_valid. o_zone_valid and o_frame_done are single-cycle.
- Reset values: all outputs 0; word counter 0; zone counter 0; accumulators 0; pipeline valid bits 0.
- Asserting reset mid-zone aborts all in-flight data; no pulse follows reset release.

## Test plan
- Zone 0, all 477 words 0x64646464 → one o_zone_valid 4 cycles after the last word; idx 0, max 100, mean 100, bl 100.
- Zone of all zeros except a single pixel 0xFF in word 200 → max 255, mean 0, bl 95.
- Two zones back-to-back at one word per cycle: all 0xFFFFFFFF, then all 0x10101010 → zone 0: 255/255/255; zone 1: 16/16/16. Zone 1 must show no carry-over from zone 0.
- i_frame_start pulsed at word 300 of zone 5, then a full zone of 0x20202020 → no output for zone 5; next output is idx 0, max 32, mean 32.
- Full 360-zone frame at 1 word per 6 clocks → 360 pulses with idx 0..359 in order. o_frame_done is asserted only with idx 359. The next zone reports idx 0.
- rst_n asserted between a zone's last word and its output → no o_zone_valid; all outputs 0 after reset.
